// File: rtl/phased_way_ctrl.sv
// phased_way_ctrl: sequencing controller for an 8-way phased cache data path.
// One lookup at a time. Phase 1 reads all tag ways; phase 2 enables only the
// hit way's data array through a one-hot select. A miss picks a round-robin
// victim, issues a refill request and waits for refill_done.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr   core-side lookup request
//   tag_rd_en, tag_addr, tag_hit   tag array strobe, latched address, match vector
//   data_rd_en, data_way_sel, data_rdata   data array strobe, one-hot way, read data
//   refill_req, refill_way, refill_done    miss refill handshake
//   resp_valid/resp_ready, resp_hit, resp_err, resp_way, resp_data   response
//
// Optional build macro PHASED_PERF_CNT_EN adds saturating 16-bit counters
// perf_hits, perf_misses and perf_errs, bumped once per response handshake.
module phased_way_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              tag_rd_en,
  output logic [ADDR_W-1:0] tag_addr,
  input  logic [7:0]        tag_hit,
  output logic              data_rd_en,
  output logic [7:0]        data_way_sel,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              refill_req,
  output logic [7:0]        refill_way,
  input  logic              refill_done,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic              resp_err,
  output logic [2:0]        resp_way,
  output logic [DATA_W-1:0] resp_data
`ifdef PHASED_PERF_CNT_EN
  ,
  output logic [15:0]       perf_hits,
  output logic [15:0]       perf_misses,
  output logic [15:0]       perf_errs
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StTagRd,
    StTagCmp,
    StDataRd,
    StDataCap,
    StMiss,
    StResp
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          way_q;
  logic [2:0]          victim_q;
  logic                resp_hit_q;
  logic                resp_err_q;
  logic [2:0]          resp_way_q;
  logic [DATA_W-1:0]   resp_data_q;

  // Tag-match classification. x & (x-1) clears the lowest set bit, so a
  // non-zero result means at least two ways matched.
  logic       hit_none;
  logic       hit_multi;
  logic [2:0] hit_idx;

  always_comb begin
    hit_none  = (tag_hit == 8'h00);
    hit_multi = |(tag_hit & (tag_hit - 8'd1));
    hit_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (tag_hit[i]) hit_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      way_q       <= '0;
      victim_q    <= '0;
      resp_hit_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_way_q  <= '0;
      resp_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            state_q <= StTagRd;
          end
        end
        StTagRd: state_q <= StTagCmp;
        StTagCmp: begin
          if (hit_none) begin
            state_q <= StMiss;
          end else if (hit_multi) begin
            resp_err_q <= 1'b1;
            resp_hit_q <= 1'b0;
            resp_way_q <= '0;
            state_q    <= StResp;
          end else begin
            way_q      <= hit_idx;
            resp_way_q <= hit_idx;
            state_q    <= StDataRd;
          end
        end
        StDataRd: state_q <= StDataCap;
        StDataCap: begin
          resp_data_q <= data_rdata;
          resp_hit_q  <= 1'b1;
          state_q     <= StResp;
        end
        StMiss: begin
          if (refill_done) begin
            resp_way_q <= victim_q;
            resp_hit_q <= 1'b0;
            victim_q   <= victim_q + 3'd1;  // wraps 7 -> 0
            state_q    <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_hit_q  <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes decode from state only, so reset removes them without a clock.
  assign req_ready    = (state_q == StIdle);
  assign tag_rd_en    = (state_q == StTagRd);
  assign tag_addr     = addr_q;
  assign data_rd_en   = (state_q == StDataRd);
  assign data_way_sel = data_rd_en ? (8'd1 << way_q) : 8'h00;
  assign refill_req   = (state_q == StMiss);
  assign refill_way   = refill_req ? (8'd1 << victim_q) : 8'h00;
  assign resp_valid   = (state_q == StResp);
  assign resp_hit     = resp_hit_q;
  assign resp_err     = resp_err_q;
  assign resp_way     = resp_way_q;
  assign resp_data    = resp_data_q;

`ifdef PHASED_PERF_CNT_EN
  logic [15:0] perf_hits_q;
  logic [15:0] perf_misses_q;
  logic [15:0] perf_errs_q;
  logic        resp_fire;

  assign resp_fire = resp_valid && resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
      perf_errs_q   <= '0;
    end else if (resp_fire) begin
      if (resp_err_q) begin
        if (perf_errs_q != 16'hFFFF) perf_errs_q <= perf_errs_q + 16'd1;
      end else if (resp_hit_q) begin
        if (perf_hits_q != 16'hFFFF) perf_hits_q <= perf_hits_q + 16'd1;
      end else begin
        if (perf_misses_q != 16'hFFFF) perf_misses_q <= perf_misses_q + 16'd1;
      end
    end
  end

  assign perf_hits   = perf_hits_q;
  assign perf_misses = perf_misses_q;
  assign perf_errs   = perf_errs_q;
`endif

endmodule

// File: tb/tb_phased_way_ctrl.sv
module tb_phased_way_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        tag_rd_en;
  logic [31:0] tag_addr;
  logic [7:0]  tag_hit = '0;
  logic        data_rd_en;
  logic [7:0]  data_way_sel;
  logic [31:0] data_rdata = '0;
  logic        refill_req;
  logic [7:0]  refill_way;
  logic        refill_done = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_hit;
  logic        resp_err;
  logic [2:0]  resp_way;
  logic [31:0] resp_data;
`ifdef PHASED_PERF_CNT_EN
  logic [15:0] perf_hits;
  logic [15:0] perf_misses;
  logic [15:0] perf_errs;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  phased_way_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .tag_rd_en    (tag_rd_en),
    .tag_addr     (tag_addr),
    .tag_hit      (tag_hit),
    .data_rd_en   (data_rd_en),
    .data_way_sel (data_way_sel),
    .data_rdata   (data_rdata),
    .refill_req   (refill_req),
    .refill_way   (refill_way),
    .refill_done  (refill_done),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_hit     (resp_hit),
    .resp_err     (resp_err),
    .resp_way     (resp_way),
    .resp_data    (resp_data)
`ifdef PHASED_PERF_CNT_EN
    ,
    .perf_hits    (perf_hits),
    .perf_misses  (perf_misses),
    .perf_errs    (perf_errs)
`endif
  );

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({req_ready, tag_rd_en, data_rd_en, refill_req, resp_valid, resp_hit, resp_err}
        !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b exp 1000000",
               {req_ready, tag_rd_en, data_rd_en, refill_req, resp_valid, resp_hit, resp_err});
    end
    tests_run++;
    if ({tag_addr, data_way_sel, refill_way, resp_way, resp_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h exp 0",
               {tag_addr, data_way_sel, refill_way, resp_way, resp_data});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_hit_way5();
    req_valid = 1'b1; req_addr = 32'h0000_1A40; tag_hit = 8'b0010_0000;
    data_rdata = 32'hDEAD_BEEF; resp_ready = 1'b0;
    step();  // TAG_RD
    req_valid = 1'b0;
    tests_run++;
    if ({tag_rd_en, tag_addr} !== {1'b1, 32'h0000_1A40}) begin
      tests_failed++;
      $display("FAIL hit_tag_rd: got en=%b addr=%h exp en=1 addr=00001a40", tag_rd_en, tag_addr);
    end
    step();  // TAG_CMP
    tests_run++;
    if ({tag_rd_en, data_rd_en} !== 2'b00) begin
      tests_failed++;
      $display("FAIL hit_tag_cmp: got tag_rd_en=%b data_rd_en=%b exp 0 0", tag_rd_en, data_rd_en);
    end
    step();  // DATA_RD
    tests_run++;
    if ({data_rd_en, data_way_sel} !== {1'b1, 8'h20}) begin
      tests_failed++;
      $display("FAIL hit_data_rd: got en=%b sel=%h exp en=1 sel=20", data_rd_en, data_way_sel);
    end
    step();  // DATA_CAP
    tests_run++;
    if ({data_rd_en, data_way_sel, resp_valid} !== 10'b0) begin
      tests_failed++;
      $display("FAIL hit_data_cap: got en=%b sel=%h valid=%b exp 0 00 0",
               data_rd_en, data_way_sel, resp_valid);
    end
    step();  // RESP, +4 from acceptance
    tests_run++;
    if ({resp_valid, resp_hit, resp_err, resp_way, resp_data}
        !== {1'b1, 1'b1, 1'b0, 3'd5, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL hit_resp: got v=%b hit=%b err=%b way=%0d data=%h exp 1 1 0 5 deadbeef",
               resp_valid, resp_hit, resp_err, resp_way, resp_data);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    tests_run++;
    if ({req_ready, resp_valid, resp_hit, resp_data} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL hit_release: got ready=%b v=%b hit=%b data=%h exp 1 0 0 0",
               req_ready, resp_valid, resp_hit, resp_data);
    end
  endtask

  // One miss with refill_done two cycles into MISS; checks victim selection.
  task automatic run_miss(input logic [2:0] vic, input logic [7:0] vic_oh);
    req_valid = 1'b1; req_addr = 32'h0000_2000 + 32'(vic); tag_hit = 8'h00;
    step();  // TAG_RD
    req_valid = 1'b0;
    step();  // TAG_CMP
    step();  // MISS, first cycle
    tests_run++;
    if ({refill_req, refill_way} !== {1'b1, vic_oh}) begin
      tests_failed++;
      $display("FAIL miss_refill: got req=%b way=%h exp req=1 way=%h", refill_req, refill_way, vic_oh);
    end
    step();  // MISS, second cycle: request must still be held
    tests_run++;
    if ({refill_req, refill_way, resp_valid} !== {1'b1, vic_oh, 1'b0}) begin
      tests_failed++;
      $display("FAIL miss_hold: got req=%b way=%h v=%b exp 1 %h 0",
               refill_req, refill_way, resp_valid, vic_oh);
    end
    refill_done = 1'b1;
    step();  // RESP
    refill_done = 1'b0;
    tests_run++;
    if ({resp_valid, resp_hit, resp_err, resp_way, refill_req, refill_way}
        !== {1'b1, 1'b0, 1'b0, vic, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL miss_resp: got v=%b hit=%b err=%b way=%0d rreq=%b rway=%h exp 1 0 0 %0d 0 00",
               resp_valid, resp_hit, resp_err, resp_way, refill_req, refill_way, vic);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_miss_seq();
    run_miss(3'd0, 8'h01);
    run_miss(3'd1, 8'h02);
    run_miss(3'd2, 8'h04);
  endtask

  task automatic test_victim_wrap();
    logic [7:0] oh;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    oh = 8'h01;
    for (int i = 0; i < 9; i++) begin
      run_miss(3'(i), oh);
      oh = {oh[6:0], oh[7]};
    end
  endtask

  task automatic test_multi_hit();
    int saw_data = 0;
    req_valid = 1'b1; req_addr = 32'h0000_3300; tag_hit = 8'b1000_0001;
    step();  // TAG_RD
    req_valid = 1'b0;
    refill_done = 1'b1;  // must be ignored outside MISS
    if (data_rd_en) saw_data++;
    step();  // TAG_CMP
    refill_done = 1'b0;
    if (data_rd_en) saw_data++;
    tests_run++;
    if (resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL multi_early: got resp_valid=%b exp 0 at +2", resp_valid);
    end
    step();  // RESP, +3
    if (data_rd_en) saw_data++;
    tests_run++;
    if ({resp_valid, resp_err, resp_hit, resp_way} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL multi_resp: got v=%b err=%b hit=%b way=%0d exp 1 1 0 0",
               resp_valid, resp_err, resp_hit, resp_way);
    end
    tests_run++;
    if (saw_data !== 0) begin
      tests_failed++;
      $display("FAIL multi_no_data: got %0d data_rd_en cycles exp 0", saw_data);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    tests_run++;
    if ({resp_err, req_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL multi_release: got err=%b ready=%b exp 0 1", resp_err, req_ready);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
`ifdef PHASED_PERF_CNT_EN
    logic [15:0] hits_before;
    hits_before = perf_hits;
`endif
    req_valid = 1'b1; req_addr = 32'h0000_4400; tag_hit = 8'b0000_0100;
    data_rdata = 32'h1234_5678;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    step();  // RESP
    req_valid = 1'b1; req_addr = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      if ({resp_valid, resp_hit, resp_err, resp_way, resp_data, req_ready, tag_addr}
          !== {1'b1, 1'b1, 1'b0, 3'd2, 32'h1234_5678, 1'b0, 32'h0000_4400}) bad++;
      step();
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL bp_stable: got %0d unstable cycles exp 0 (v=%b way=%0d data=%h ready=%b)",
               bad, resp_valid, resp_way, resp_data, req_ready);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    tests_run++;
    if ({req_ready, resp_valid, tag_rd_en} !== 3'b100) begin
      tests_failed++;
      $display("FAIL bp_release: got ready=%b v=%b tag_rd_en=%b exp 1 0 0",
               req_ready, resp_valid, tag_rd_en);
    end
`ifdef PHASED_PERF_CNT_EN
    tests_run++;
    if (perf_hits !== hits_before + 16'd1) begin
      tests_failed++;
      $display("FAIL bp_perf_hits: got %0d exp %0d", perf_hits, hits_before + 16'd1);
    end
`endif
  endtask

  task automatic test_reset_mid_data_rd();
    req_valid = 1'b1; req_addr = 32'h0000_5500; tag_hit = 8'b0000_1000;
    step();
    req_valid = 1'b0;
    step();
    step();  // DATA_RD
    tests_run++;
    if ({data_rd_en, data_way_sel} !== {1'b1, 8'h08}) begin
      tests_failed++;
      $display("FAIL rst_pre: got en=%b sel=%h exp 1 08", data_rd_en, data_way_sel);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({data_rd_en, data_way_sel, req_ready} !== {1'b0, 8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL rst_async: got en=%b sel=%h ready=%b exp 0 00 1",
               data_rd_en, data_way_sel, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // Victim pointer was 1 after the wrap test; reset must bring it back to 0.
    run_miss(3'd0, 8'h01);
  endtask

  initial begin
    test_reset();
    test_hit_way5();
    test_miss_seq();
    test_victim_wrap();
    test_multi_hit();
    test_backpressure();
    test_reset_mid_data_rd();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/phased_way_ctrl.md
Name: phased_way_ctrl

Overview:
- Sequencing controller for the 8-way phased cache data path. Accepts one lookup request at a time and runs the two phases in order. Phase 1 reads all tags. Phase 2 enables only the single hit way's data array, using a one-hot way select (3-to-8 decode of the encoded hit way).
- On a miss, picks a round-robin victim way, issues a refill request and waits for it to complete.
- Sits between the core-side request port and the tag/data arrays.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data array read width

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  lookup request valid
req_ready  output  1  controller can accept a request
req_addr  input  ADDR_W  lookup address
tag_rd_en  output  1  tag arrays read strobe, all 8 ways
tag_addr  output  ADDR_W  latched request address to tag/data arrays
tag_hit  input  8  per-way tag-match vector, valid the cycle after tag_rd_en
data_rd_en  output  1  data array read strobe
data_way_sel  output  8  one-hot data-way enable; all zero when data_rd_en=0
data_rdata  input  DATA_W  selected-way data, valid the cycle after data_rd_en
refill_req  output  1  miss refill request; held until refill_done
refill_way  output  8  one-hot victim way; valid while refill_req=1
refill_done  input  1  refill complete, single-cycle pulse
resp_valid  output  1  response valid
resp_ready  input  1  requester accepts response
resp_hit  output  1  1=hit, 0=miss (refilled)
resp_err  output  1  multiple tag_hit bits set
resp_way  output  3  encoded way: hit way, or victim on miss
resp_data  output  DATA_W  read data on hit; zero otherwise

Behaviour:
- Required states: IDLE, TAG_RD, TAG_CMP, DATA_RD, DATA_CAP, MISS, RESP. All outputs are decoded from state and registers; there is no combinational path from any input to any output.
- Reset (rst_n low, asynchronous):
  - state=IDLE, victim pointer=0, all registers cleared.
  - req_ready=1. All other outputs 0.
  - Reset in any state aborts the access and drops any pending refill_req immediately.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_addr into tag_addr, go to TAG_RD.
- TAG_RD: tag_rd_en=1 for exactly one cycle, then go to TAG_CMP.
- TAG_CMP (samples tag_hit):
  - Exactly one bit set: store encoded index in way register, go to DATA_RD.
  - Zero bits set: go to MISS.
  - Two or more bits set: set resp_err=1, resp_hit=0, resp_way=0, go to RESP. No data read is issued.
- DATA_RD:
  - data_rd_en=1 and data_way_sel = 1 << way, for exactly one cycle.
  - Go to DATA_CAP.
- DATA_CAP:
  - Capture data_rdata into resp_data, set resp_hit=1.
  - Go to RESP.
- MISS:
  - refill_req=1, refill_way = 1 << victim pointer, both held stable.
  - On refill_done: resp_way = victim, resp_hit=0, victim pointer increments mod 8 (7 wraps to 0), go to RESP.
  - refill_done sampled in any other state is ignored.
- RESP:
  - resp_valid=1; resp_* held stable until resp_ready.
  - On resp_ready: clear resp_hit/resp_err/resp_data, go to IDLE.
  - req_ready=0 here. A request can be accepted no earlier than the cycle after the handshake.
- Latency, request acceptance edge to resp_valid: hit = 4 cycles; error = 3 cycles; miss = 3 cycles plus refill wait.
- Victim pointer advances only on completed refills, never on hits or errors.
- tag_addr holds its value from acceptance until the next acceptance.

Optional Feature:
- Macro: PHASED_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_hits[15:0], perf_misses[15:0], perf_errs[15:0].
  - Each counter increments once per completed response handshake of that type and saturates at 16'hFFFF.
  - Cleared by rst_n.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-DATA_RD: assert rst_n=0 -> same cycle data_rd_en=0, data_way_sel=8'h00, req_ready=1; after release, victim pointer=0.
- Hit way 5: req_addr=32'h0000_1A40, tag_hit=8'b0010_0000, data_rdata=32'hDEAD_BEEF -> tag_rd_en one cycle, data_way_sel=8'h20 one cycle, resp_valid at +4 with resp_hit=1, resp_way=5, resp_data=32'hDEAD_BEEF.
- Miss sequence: three requests with tag_hit=0, refill_done after 2 cycles each -> refill_way=8'h01, 8'h02, 8'h04; resp_hit=0; resp_way=0,1,2.
- Victim wrap: nine consecutive misses -> ninth refill_way=8'h01.
- Multi-hit: tag_hit=8'b1000_0001 -> no data_rd_en pulse, resp_err=1, resp_hit=0, resp_valid at +3.
- Backpressure: resp_ready=0 for 5 cycles after hit -> resp_* stable, req_ready=0, req_valid ignored; resp_ready=1 -> IDLE next cycle; with PHASED_PERF_CNT_EN defined, perf_hits increments by exactly 1.
